mem_port_arbiter: RTL and testbench

- Shares the single sram-like memory port between the IF-stage instruction requester and the EX-stage data requester (data_sram_* side).
- Uses the split req/addr_ok/data_ok protocol, so the pipeline can overlap fetch and load/store traffic.
- Tracks outstanding transactions in an owner FIFO and routes in-order responses back to the requester that issued them.
- Sits between the CPU core and the memory/bridge interface.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one sram-like memory port between the instruction fetch requester
//   (inst_*) and the data requester (data_*). It uses the split
//   req/addr_ok/data_ok protocol.
//   - Grant is combinational: data wins over inst unless a lock is held.
//   - A pending (req && !addr_ok) request locks the grant until accepted,
//     so the presented request never changes while it is pending.
//   - Accepted transactions push their owner into a FIFO. In-order responses
//     pop it and strobe the matching *_data_ok.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   inst_req/addr, inst_*_ok    instruction read requester
//   inst_rdata                  instruction read data (mirrors mem_rdata)
//   data_req/wr/wstrb/addr/wdata, data_*_ok, data_rdata   data requester
//   mem_req/wr/wstrb/addr/wdata memory request side
//   mem_addr_ok/data_ok/rdata   memory handshake and read data
module mem_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned OWNER_W         = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [OWNER_W-1:0] CNT_MAX  = OWNER_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    logic [OWNER_W-1:0]         count_q, count_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;   // 1 = data, 0 = inst
    logic                       lock_vld_q, lock_vld_d;
    logic                       lock_owner_q, lock_owner_d;

    logic grant_data;
    logic push;
    logic pop;
    logic head_owner;

    // Grant and request mux
    always_comb begin
        grant_data = lock_vld_q ? lock_owner_q : data_req;
        mem_req    = (inst_req | data_req) && (count_q < CNT_MAX) && !reset;
        if (grant_data) begin
            mem_wr    = data_wr;
            mem_wstrb = data_wr ? data_wstrb : 4'b0000;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else begin
            mem_wr    = 1'b0;
            mem_wstrb = 4'b0000;
            mem_addr  = inst_addr;
            mem_wdata = data_wdata;
        end
    end

    // Handshakes; a response with an empty FIFO is a stray and is dropped
    always_comb begin
        push         = mem_req & mem_addr_ok;
        pop          = mem_data_ok && (count_q != '0) && !reset;
        head_owner   = owner_q[rd_ptr_q];
        inst_addr_ok = push & ~grant_data;
        data_addr_ok = push & grant_data;
        inst_data_ok = pop & ~head_owner;
        data_data_ok = pop & head_owner;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    // Next state: owner FIFO, count and lock
    always_comb begin
        owner_d      = owner_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        lock_vld_d   = lock_vld_q;
        lock_owner_d = lock_owner_q;

        if (push) begin
            owner_d[wr_ptr_q] = grant_data;
            wr_ptr_d          = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // mem_req is low when full, so the lock holds its value then
        if (mem_req && !mem_addr_ok) begin
            lock_vld_d   = 1'b1;
            lock_owner_d = grant_data;
        end else if (push) begin
            lock_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            owner_q      <= '0;
            lock_vld_q   <= 1'b0;
            lock_owner_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            owner_q      <= owner_d;
            lock_vld_q   <= lock_vld_d;
            lock_owner_q <= lock_owner_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MAX_OUTSTANDING(2),
        .OWNER_W        (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_wstrb  (data_wstrb),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_wstrb   (mem_wstrb),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        inst_req    = 1'b0;
        inst_addr   = 32'h0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_wstrb  = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    // Inputs change 1 ns after posedge; outputs are checked at negedge
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] addr);
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_addr = addr;
    endtask

    task automatic respond(input logic [31:0] rdata);
        mem_data_ok = 1'b1;
        mem_rdata   = rdata;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        // Reset gating with requests and a response present
        inst_req    = 1'b1;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_inst_addr_ok", inst_addr_ok, 0);
        check("rst_inst_data_ok", inst_data_ok, 0);
        next();
        idle();
        next();
        reset = 1'b0;
        check("rst_count", dut.count_q, 0);

        // Single fetch
        inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
        @(negedge clk);
        check("fetch_addr_ok", inst_addr_ok, 1);
        check("fetch_mem_wr", mem_wr, 0);
        check("fetch_mem_addr", mem_addr, 32'h1c00_0000);
        check("fetch_data_addr_ok", data_addr_ok, 0);
        next(); idle();
        check("fetch_count1", dut.count_q, 1);
        next();
        respond(32'h0280_0000);
        @(negedge clk);
        check("fetch_data_ok", inst_data_ok, 1);
        check("fetch_rdata", inst_rdata, 32'h0280_0000);
        check("fetch_no_ddok", data_data_ok, 0);
        next(); idle();
        check("fetch_count0", dut.count_q, 0);

        // Contention: data store wins, inst follows
        inst_req = 1'b1; inst_addr = 32'h1c00_0004;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h100; data_wstrb = 4'b0011;
        data_wdata = 32'hdead_beef; mem_addr_ok = 1'b1;
        @(negedge clk);
        check("cont_mem_addr", mem_addr, 32'h100);
        check("cont_mem_wstrb", mem_wstrb, 4'b0011);
        check("cont_mem_wr", mem_wr, 1);
        check("cont_mem_wdata", mem_wdata, 32'hdead_beef);
        check("cont_data_addr_ok", data_addr_ok, 1);
        check("cont_inst_addr_ok", inst_addr_ok, 0);
        next();
        data_req = 1'b0; data_wr = 1'b0;
        @(negedge clk);
        check("cont2_mem_addr", mem_addr, 32'h1c00_0004);
        check("cont2_inst_addr_ok", inst_addr_ok, 1);
        check("cont2_mem_wstrb", mem_wstrb, 0);
        next(); idle();
        respond(32'h0);
        @(negedge clk);
        check("cont_store_done", data_data_ok, 1);
        check("cont_store_no_idok", inst_data_ok, 0);
        next();
        respond(32'h1234_5678);
        @(negedge clk);
        check("cont_inst_data_ok", inst_data_ok, 1);
        check("cont_inst_rdata", inst_rdata, 32'h1234_5678);
        next(); idle();
        check("cont_count0", dut.count_q, 0);

        // Lock: pending inst keeps the port while data arrives
        inst_req = 1'b1; inst_addr = 32'h1c00_0008;
        @(negedge clk);
        check("lock1_mem_addr", mem_addr, 32'h1c00_0008);
        next();
        load(32'h200);
        @(negedge clk);
        check("lock2_mem_addr", mem_addr, 32'h1c00_0008);
        check("lock2_data_addr_ok", data_addr_ok, 0);
        next();
        @(negedge clk);
        check("lock3_mem_addr", mem_addr, 32'h1c00_0008);
        next();
        mem_addr_ok = 1'b1;
        @(negedge clk);
        check("lock4_inst_addr_ok", inst_addr_ok, 1);
        check("lock4_data_addr_ok", data_addr_ok, 0);
        next();
        inst_req = 1'b0;
        @(negedge clk);
        check("lock5_mem_addr", mem_addr, 32'h200);
        check("lock5_data_addr_ok", data_addr_ok, 1);
        next(); idle();
        respond(32'h0000_00aa);
        @(negedge clk);
        check("lock_resp1_inst", inst_data_ok, 1);
        next();
        respond(32'h0000_00bb);
        @(negedge clk);
        check("lock_resp2_data", data_data_ok, 1);
        check("lock_resp2_rdata", data_rdata, 32'h0000_00bb);
        next(); idle();

        // Full: two loads outstanding block a third
        load(32'h300); mem_addr_ok = 1'b1;
        @(negedge clk);
        check("full_ld1_ok", data_addr_ok, 1);
        next();
        data_addr = 32'h304;
        @(negedge clk);
        check("full_ld2_ok", data_addr_ok, 1);
        next();
        data_addr = 32'h308;
        @(negedge clk);
        check("full_mem_req", mem_req, 0);
        check("full_no_addr_ok", data_addr_ok, 0);
        next();
        respond(32'h11);
        @(negedge clk);
        check("full_pop_ddok", data_data_ok, 1);
        check("full_pop_rdata", data_rdata, 32'h11);
        check("full_pop_no_accept", data_addr_ok, 0);
        next();
        mem_data_ok = 1'b0;
        @(negedge clk);
        check("full_reassert_req", mem_req, 1);
        check("full_reassert_ok", data_addr_ok, 1);
        next();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        respond(32'h22);
        @(negedge clk);
        check("full_pop2_ddok", data_data_ok, 1);
        next();
        // Push and pop together at count 1
        load(32'h30c); mem_addr_ok = 1'b1; respond(32'h33);
        @(negedge clk);
        check("pp_addr_ok", data_addr_ok, 1);
        check("pp_data_ok", data_data_ok, 1);
        next(); idle();
        check("pp_count", dut.count_q, 1);
        respond(32'h44);
        @(negedge clk);
        check("pp_last_ddok", data_data_ok, 1);
        next(); idle();
        check("pp_count0", dut.count_q, 0);

        // Ordering: data, inst, data
        load(32'h400); mem_addr_ok = 1'b1;
        @(negedge clk);
        check("ord_d1_ok", data_addr_ok, 1);
        next();
        data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1c00_0010;
        @(negedge clk);
        check("ord_i_ok", inst_addr_ok, 1);
        next();
        inst_req = 1'b0; mem_addr_ok = 1'b0; respond(32'ha);
        @(negedge clk);
        check("ord_resp_a_d", data_data_ok, 1);
        check("ord_resp_a_i", inst_data_ok, 0);
        check("ord_resp_a_rdata", data_rdata, 32'ha);
        next();
        mem_data_ok = 1'b0; load(32'h404); mem_addr_ok = 1'b1;
        @(negedge clk);
        check("ord_d2_ok", data_addr_ok, 1);
        next(); idle();
        respond(32'hb);
        @(negedge clk);
        check("ord_resp_b_i", inst_data_ok, 1);
        check("ord_resp_b_d", data_data_ok, 0);
        check("ord_resp_b_rdata", inst_rdata, 32'hb);
        next();
        respond(32'hc);
        @(negedge clk);
        check("ord_resp_c_d", data_data_ok, 1);
        check("ord_resp_c_i", inst_data_ok, 0);
        next(); idle();

        // Reset with two outstanding, then a stray response
        load(32'h500); mem_addr_ok = 1'b1;
        next();
        data_addr = 32'h504;
        next();
        check("rst2_count_pre", dut.count_q, 2);
        reset = 1'b1; inst_req = 1'b1; respond(32'h55);
        @(negedge clk);
        check("rst2_mem_req", mem_req, 0);
        check("rst2_data_addr_ok", data_addr_ok, 0);
        check("rst2_data_data_ok", data_data_ok, 0);
        check("rst2_inst_data_ok", inst_data_ok, 0);
        next();
        reset = 1'b0; idle();
        check("rst2_count", dut.count_q, 0);
        respond(32'h66);
        @(negedge clk);
        check("stray_ddok", data_data_ok, 0);
        check("stray_idok", inst_data_ok, 0);
        next(); idle();
        check("stray_count", dut.count_q, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
